// File: rtl/da_result_checker_if.sv
// rtl/da_result_checker_if.sv - stimulus and DUT-result signals observed by da_result_checker
//
// Ports (master drives, slave observes):
//   gen_done          generator has produced its first weight set
//   update_pulse_addr addr_array is new this cycle
//   update_pulse_b    B_temp is new this cycle
//   addr_array        K-1 address bits; full address is {addr_array, 1'b1}
//   B_temp            K signed weights of DATA_WIDTH_B bits
//   dut_valid         DUT result valid this cycle
//   dut_result        signed DUT result, SUM_W bits
interface da_result_checker_if #(
    parameter int K            = 8,
    parameter int DATA_WIDTH_B = 8,
    parameter int SUM_W        = DATA_WIDTH_B + $clog2(K)
);
    logic                                 gen_done;
    logic                                 update_pulse_addr;
    logic                                 update_pulse_b;
    logic [K-2:0]                         addr_array;
    logic [K-1:0][DATA_WIDTH_B-1:0]       B_temp;
    logic                                 dut_valid;
    logic signed [SUM_W-1:0]              dut_result;

    modport master (
        output gen_done, update_pulse_addr, update_pulse_b,
        output addr_array, B_temp, dut_valid, dut_result
    );

    modport slave (
        input gen_done, update_pulse_addr, update_pulse_b,
        input addr_array, B_temp, dut_valid, dut_result
    );
endinterface

// File: rtl/da_result_checker.sv
// rtl/da_result_checker.sv - golden DA partial-sum scoreboard checking a DA unit result stream
//
// Optional feature macro: DA_CHK_STOP_ON_FAIL_EN (freeze in HALT on first mismatch).
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   enable            checking enabled
//   clear             synchronous clear of all checker state (highest priority)
//   bus               da_result_checker_if.slave: stimulus samples and DUT results
//   state_o           0 IDLE, 1 WAIT_GEN, 2 RUN, 3 HALT
//   fifo_level        number of queued expected values (0..DEPTH)
//   pass_cnt/fail_cnt saturating compare counters
//   err_flag          sticky mismatch
//   ovf_flag          sticky dropped expected value
//   unf_flag          sticky DUT result with no expected value queued
//   first_fail_*      expected value, DUT value and compare index of the first mismatch
module da_result_checker #(
    parameter int K            = 8,
    parameter int DATA_WIDTH_B = 8,
    parameter int DEPTH        = 8,
    parameter int SUM_W        = DATA_WIDTH_B + $clog2(K)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     clear,
    da_result_checker_if.slave       bus,
    output logic [1:0]               state_o,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [31:0]              pass_cnt,
    output logic [31:0]              fail_cnt,
    output logic                     err_flag,
    output logic                     ovf_flag,
    output logic                     unf_flag,
    output logic [SUM_W-1:0]         first_fail_exp,
    output logic [SUM_W-1:0]         first_fail_got,
    output logic [31:0]              first_fail_idx
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_GEN = 2'd1,
        S_RUN      = 2'd2,
        S_HALT     = 2'd3
    } state_t;

    state_t                  state;
    logic [SUM_W-1:0]        mem [DEPTH];
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic signed [SUM_W-1:0] exp_q;
    logic                    exp_vld;
    logic [31:0]             cmp_idx;

    logic signed [SUM_W-1:0] gold;
    logic                    run;
    logic                    sample;
    logic                    empty;
    logic                    full;
    logic                    pop;
    logic                    push_ok;
    logic                    push_drop;
    logic                    mismatch;
    logic                    unused_pulse_b;

    assign state_o        = state;
    assign unused_pulse_b = bus.update_pulse_b;

    // Full-address bit 0 is hard-wired to 1, so weight 0 always contributes.
    always_comb begin
        gold = {{(SUM_W-DATA_WIDTH_B){bus.B_temp[0][DATA_WIDTH_B-1]}}, bus.B_temp[0]};
        for (int j = 1; j < K; j++) begin
            if (bus.addr_array[j-1]) begin
                gold = gold + {{(SUM_W-DATA_WIDTH_B){bus.B_temp[j][DATA_WIDTH_B-1]}}, bus.B_temp[j]};
            end
        end
    end

    always_comb begin
        run       = (state == S_RUN);
        sample    = run && bus.update_pulse_addr;
        empty     = (fifo_level == '0);
        full      = (fifo_level == LW'(DEPTH));
        // Pop looks only at registered level, so a fresh push is never bypassed.
        pop       = run && bus.dut_valid && !empty;
        // A registered sample still lands after RUN is left, except into a frozen HALT.
        push_ok   = exp_vld && (state != S_HALT) && (!full || pop);
        push_drop = exp_vld && (state != S_HALT) && full && !pop;
        mismatch  = pop && (mem[rd_ptr] != bus.dut_result);
    end

    always_ff @(posedge clk) begin
        if (push_ok && !clear) begin
            mem[wr_ptr] <= exp_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            fifo_level     <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            exp_q          <= '0;
            exp_vld        <= 1'b0;
            cmp_idx        <= '0;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            err_flag       <= 1'b0;
            ovf_flag       <= 1'b0;
            unf_flag       <= 1'b0;
            first_fail_exp <= '0;
            first_fail_got <= '0;
            first_fail_idx <= '0;
        end else if (clear) begin
            state          <= S_IDLE;
            fifo_level     <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            exp_q          <= '0;
            exp_vld        <= 1'b0;
            cmp_idx        <= '0;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            err_flag       <= 1'b0;
            ovf_flag       <= 1'b0;
            unf_flag       <= 1'b0;
            first_fail_exp <= '0;
            first_fail_got <= '0;
            first_fail_idx <= '0;
        end else begin
            exp_vld <= sample;
            if (sample) begin
                exp_q <= gold;
            end

            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (push_drop) begin
                ovf_flag <= 1'b1;
            end
            fifo_level <= fifo_level + LW'(push_ok) - LW'(pop);

            if (run && bus.dut_valid && empty) begin
                unf_flag <= 1'b1;
            end

            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                if (cmp_idx != '1) begin
                    cmp_idx <= cmp_idx + 32'd1;
                end
                if (mismatch) begin
                    if (fail_cnt != '1) begin
                        fail_cnt <= fail_cnt + 32'd1;
                    end
                    if (!err_flag) begin
                        first_fail_exp <= mem[rd_ptr];
                        first_fail_got <= bus.dut_result;
                        first_fail_idx <= cmp_idx;
                    end
                    err_flag <= 1'b1;
                end else if (pass_cnt != '1) begin
                    pass_cnt <= pass_cnt + 32'd1;
                end
            end

            case (state)
                S_IDLE: begin
                    if (enable) state <= S_WAIT_GEN;
                end
                S_WAIT_GEN: begin
                    if (bus.gen_done) state <= S_RUN;
                end
                S_RUN: begin
`ifdef DA_CHK_STOP_ON_FAIL_EN
                    if (mismatch) state <= S_HALT;
                    else if (!enable) state <= S_IDLE;
`else
                    if (!enable) state <= S_IDLE;
`endif
                end
                default: begin
`ifdef DA_CHK_STOP_ON_FAIL_EN
                    state <= S_HALT;
`else
                    state <= S_IDLE;
`endif
                end
            endcase
        end
    end
endmodule

// File: tb/tb_da_result_checker.sv
// tb/tb_da_result_checker.sv - scoreboard testbench for da_result_checker
module tb_da_result_checker;
    localparam int K     = 8;
    localparam int W     = 8;
    localparam int DEPTH = 8;
    localparam int SUM_W = W + $clog2(K);

    typedef logic signed [SUM_W-1:0] sum_t;

    logic clk = 1'b0;
    logic rst;
    logic enable;
    logic clear;
    logic [1:0]             state_o;
    logic [$clog2(DEPTH):0] fifo_level;
    logic [31:0]            pass_cnt;
    logic [31:0]            fail_cnt;
    logic                   err_flag;
    logic                   ovf_flag;
    logic                   unf_flag;
    logic [SUM_W-1:0]       first_fail_exp;
    logic [SUM_W-1:0]       first_fail_got;
    logic [31:0]            first_fail_idx;

    always #5 clk = ~clk;

    da_result_checker_if #(.K(K), .DATA_WIDTH_B(W), .SUM_W(SUM_W)) bus ();

    da_result_checker #(.K(K), .DATA_WIDTH_B(W), .DEPTH(DEPTH), .SUM_W(SUM_W)) dut (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear), .bus(bus),
        .state_o(state_o), .fifo_level(fifo_level), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
        .err_flag(err_flag), .ovf_flag(ovf_flag), .unf_flag(unf_flag),
        .first_fail_exp(first_fail_exp), .first_fail_got(first_fail_got),
        .first_fail_idx(first_fail_idx)
    );

    int tests  = 0;
    int failed = 0;

    logic signed [W-1:0] bv [K];
    sum_t        m_q [$];
    int unsigned m_pass, m_fail, m_idx, m_ffi;
    bit          m_err, m_ovf, m_unf, m_active, m_halt;
    sum_t        m_ffe, m_ffg;

    function automatic sum_t golden(input logic [K-2:0] a);
        sum_t s;
        s = sum_t'(bv[0]);
        for (int j = 1; j < K; j++) if (a[j-1]) s = s + sum_t'(bv[j]);
        return s;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_pass = 0; m_fail = 0; m_idx = 0; m_ffi = 0;
        m_err = 0; m_ovf = 0; m_unf = 0; m_active = 0; m_halt = 0;
        m_ffe = '0; m_ffg = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_b_all(input logic signed [W-1:0] v);
        for (int j = 0; j < K; j++) bv[j] = v;
    endtask

    task automatic set_b_rand();
        for (int j = 0; j < K; j++) bv[j] = W'($urandom);
    endtask

    task automatic pulse(input logic [K-2:0] a);
        bus.addr_array = a;
        for (int j = 0; j < K; j++) bus.B_temp[j] = bv[j];
        bus.update_pulse_addr = 1'b1;
        bus.update_pulse_b    = 1'b1;
        tick();
        bus.update_pulse_addr = 1'b0;
        bus.update_pulse_b    = 1'b0;
        if (m_active && !m_halt) begin
            if (m_q.size() < DEPTH) m_q.push_back(golden(a));
            else m_ovf = 1;
        end
        tick();
    endtask

    task automatic result(input sum_t v);
        sum_t e;
        bus.dut_valid  = 1'b1;
        bus.dut_result = v;
        tick();
        bus.dut_valid = 1'b0;
        if (m_active && !m_halt) begin
            if (m_q.size() == 0) begin
                m_unf = 1;
            end else begin
                e = m_q.pop_front();
                if (e == v) begin
                    m_pass++;
                end else begin
                    m_fail++;
                    if (!m_err) begin
                        m_ffe = e; m_ffg = v; m_ffi = m_idx;
                    end
                    m_err = 1;
`ifdef DA_CHK_STOP_ON_FAIL_EN
                    m_halt = 1;
`endif
                end
                m_idx++;
            end
        end
    endtask

    task automatic do_clear();
        clear = 1'b1; enable = 1'b0; bus.gen_done = 1'b0;
        tick();
        clear = 1'b0;
        model_reset();
    endtask

    task automatic start();
        enable = 1'b1; bus.gen_done = 1'b1;
        tick();
        tick();
        m_active = 1;
        tests++; if (state_o !== 2'd2) begin failed++; $display("FAIL start_state got=%0d exp=2", state_o); end
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; clear = 1'b0;
        bus.gen_done = 1'b0; bus.update_pulse_addr = 1'b0; bus.update_pulse_b = 1'b0;
        bus.addr_array = '0; bus.B_temp = '0; bus.dut_valid = 1'b0; bus.dut_result = '0;
        model_reset();
        tick(); tick();
        rst = 1'b0;
        tick();
        tests++; if (state_o !== 2'd0) begin failed++; $display("FAIL reset_state got=%0d exp=0", state_o); end
        tests++; if (fifo_level !== '0) begin failed++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
        tests++; if (pass_cnt !== 32'd0 || fail_cnt !== 32'd0) begin failed++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", pass_cnt, fail_cnt); end
        tests++; if ({err_flag, ovf_flag, unf_flag} !== 3'b000) begin failed++; $display("FAIL reset_flags got=%b exp=000", {err_flag, ovf_flag, unf_flag}); end
        tests++; if (first_fail_exp !== '0 || first_fail_got !== '0 || first_fail_idx !== 32'd0) begin failed++; $display("FAIL reset_first got=%0d/%0d/%0d exp=0/0/0", first_fail_exp, first_fail_got, first_fail_idx); end
    endtask

    task automatic test_basic();
        do_clear(); start();
        set_b_all(8'sd1);
        pulse(7'h7F);
        tests++; if (fifo_level !== 4'd1) begin failed++; $display("FAIL basic_level1 got=%0d exp=1", fifo_level); end
        result(11'sd8);
        tests++; if (pass_cnt !== 32'd1 || pass_cnt !== m_pass) begin failed++; $display("FAIL basic_pass got=%0d exp=1", pass_cnt); end
        tests++; if (fail_cnt !== 32'd0) begin failed++; $display("FAIL basic_fail got=%0d exp=0", fail_cnt); end
        tests++; if (fifo_level !== '0) begin failed++; $display("FAIL basic_level0 got=%0d exp=0", fifo_level); end
    endtask

    task automatic test_bit0();
        do_clear(); start();
        for (int j = 0; j < K; j++) bv[j] = W'(j + 1);
        pulse(7'h00);
        result(11'sd1);
        pulse(7'h00);
        result(11'sd2);
        tests++; if (pass_cnt !== 32'd1) begin failed++; $display("FAIL bit0_pass got=%0d exp=1", pass_cnt); end
        tests++; if (fail_cnt !== 32'd1 || !err_flag) begin failed++; $display("FAIL bit0_fail got=%0d err=%b exp=1 err=1", fail_cnt, err_flag); end
        tests++; if ($signed(first_fail_exp) !== 11'sd1 || $signed(first_fail_got) !== 11'sd2) begin failed++; $display("FAIL bit0_capture got=%0d/%0d exp=1/2", $signed(first_fail_exp), $signed(first_fail_got)); end
        tests++; if (first_fail_idx !== 32'd1) begin failed++; $display("FAIL bit0_idx got=%0d exp=1", first_fail_idx); end
    endtask

    task automatic test_extremes();
        do_clear(); start();
        set_b_all(-8'sd128);
        pulse(7'h7F);
        result(-11'sd1024);
        set_b_all(8'sd127);
        pulse(7'h7F);
        result(11'sd1016);
        tests++; if (pass_cnt !== 32'd2) begin failed++; $display("FAIL extremes_pass got=%0d exp=2", pass_cnt); end
        tests++; if (fail_cnt !== 32'd0 || err_flag !== 1'b0) begin failed++; $display("FAIL extremes_fail got=%0d exp=0", fail_cnt); end
    endtask

    task automatic test_overflow();
        do_clear(); start();
        for (int i = 0; i < DEPTH + 1; i++) begin
            set_b_rand();
            pulse(7'($urandom));
        end
        tests++; if (fifo_level !== 4'd8) begin failed++; $display("FAIL ovf_level got=%0d exp=8", fifo_level); end
        tests++; if (ovf_flag !== 1'b1 || ovf_flag !== m_ovf) begin failed++; $display("FAIL ovf_flag got=%b exp=1", ovf_flag); end
        while (m_q.size() > 0) result(m_q[0]);
        tests++; if (pass_cnt !== 32'd8 || fail_cnt !== 32'd0) begin failed++; $display("FAIL ovf_drain got=%0d/%0d exp=8/0", pass_cnt, fail_cnt); end
        tests++; if (fifo_level !== '0) begin failed++; $display("FAIL ovf_level0 got=%0d exp=0", fifo_level); end
    endtask

    task automatic test_underflow_gating();
        do_clear(); start();
        result(11'sd5);
        tests++; if (unf_flag !== 1'b1) begin failed++; $display("FAIL unf_flag got=%b exp=1", unf_flag); end
        tests++; if (pass_cnt !== 32'd0 || fail_cnt !== 32'd0) begin failed++; $display("FAIL unf_cnt got=%0d/%0d exp=0/0", pass_cnt, fail_cnt); end
        set_b_all(8'sd3);
        pulse(7'h01);
        result(11'sd0);
        tests++; if (first_fail_idx !== 32'd0 || $signed(first_fail_exp) !== 11'sd6) begin failed++; $display("FAIL unf_idx got=%0d/%0d exp=0/6", first_fail_idx, $signed(first_fail_exp)); end
        do_clear();
        enable = 1'b1; bus.gen_done = 1'b0;
        tick();
        pulse(7'h7F);
        pulse(7'h11);
        result(11'sd4);
        tests++; if (state_o !== 2'd1) begin failed++; $display("FAIL gate_state got=%0d exp=1", state_o); end
        tests++; if (fifo_level !== '0 || unf_flag !== 1'b0) begin failed++; $display("FAIL gate_level got=%0d unf=%b exp=0 unf=0", fifo_level, unf_flag); end
        bus.gen_done = 1'b1;
        tick();
        m_active = 1;
        tests++; if (state_o !== 2'd2) begin failed++; $display("FAIL gate_run got=%0d exp=2", state_o); end
    endtask

    task automatic test_back_to_back();
        sum_t newv;
        do_clear(); start();
        for (int i = 0; i < DEPTH; i++) begin
            set_b_rand();
            pulse(7'($urandom));
        end
        set_b_rand();
        bus.addr_array = 7'h55;
        for (int j = 0; j < K; j++) bus.B_temp[j] = bv[j];
        newv = golden(7'h55);
        bus.update_pulse_addr = 1'b1;
        tick();
        bus.update_pulse_addr = 1'b0;
        bus.dut_valid  = 1'b1;
        bus.dut_result = m_q[0];
        tick();
        bus.dut_valid = 1'b0;
        void'(m_q.pop_front());
        m_pass++; m_idx++;
        m_q.push_back(newv);
        tests++; if (fifo_level !== 4'd8 || ovf_flag !== 1'b0) begin failed++; $display("FAIL b2b_level got=%0d ovf=%b exp=8 ovf=0", fifo_level, ovf_flag); end
        tests++; if (pass_cnt !== 32'd1) begin failed++; $display("FAIL b2b_pass got=%0d exp=1", pass_cnt); end
        while (m_q.size() > 0) result(m_q[0]);
        tests++; if (pass_cnt !== 32'd9 || fail_cnt !== 32'd0) begin failed++; $display("FAIL b2b_drain got=%0d/%0d exp=9/0", pass_cnt, fail_cnt); end
    endtask

    task automatic test_disable_hold();
        do_clear(); start();
        set_b_rand();
        pulse(7'h2A);
        pulse(7'h15);
        result(m_q[0]);
        enable = 1'b0;
        tick();
        m_active = 0;
        tests++; if (state_o !== 2'd0 || fifo_level !== 4'd1) begin failed++; $display("FAIL dis_hold got=%0d/%0d exp=0/1", state_o, fifo_level); end
        result(11'sd0);
        pulse(7'h7F);
        tests++; if (pass_cnt !== 32'd1 || unf_flag !== 1'b0 || fifo_level !== 4'd1) begin failed++; $display("FAIL dis_ignore got=%0d/%b/%0d exp=1/0/1", pass_cnt, unf_flag, fifo_level); end
        start();
        result(m_q[0]);
        tests++; if (pass_cnt !== 32'd2 || fifo_level !== '0) begin failed++; $display("FAIL dis_resume got=%0d/%0d exp=2/0", pass_cnt, fifo_level); end
    endtask

    task automatic test_async_reset();
        do_clear(); start();
        set_b_all(8'sd2);
        pulse(7'h03);
        #2 rst = 1'b1;
        #1;
        model_reset();
        tests++; if (state_o !== 2'd0 || fifo_level !== '0) begin failed++; $display("FAIL arst_now got=%0d/%0d exp=0/0", state_o, fifo_level); end
        tick();
        rst = 1'b0;
        tick();
        tests++; if (state_o !== 2'd1) begin failed++; $display("FAIL arst_wait got=%0d exp=1", state_o); end
        tick();
        m_active = 1;
        tests++; if (state_o !== 2'd2 || pass_cnt !== 32'd0) begin failed++; $display("FAIL arst_run got=%0d/%0d exp=2/0", state_o, pass_cnt); end
    endtask

    task automatic test_stop_on_fail();
        do_clear(); start();
        set_b_rand();
        for (int i = 0; i < 4; i++) pulse(7'($urandom));
        result(m_q[0]);
        result(m_q[0]);
        result(m_q[0] + 11'sd1);
`ifdef DA_CHK_STOP_ON_FAIL_EN
        tests++; if (state_o !== 2'd3) begin failed++; $display("FAIL halt_state got=%0d exp=3", state_o); end
        pulse(7'h7F);
        result(11'sd0);
        tests++; if (pass_cnt !== 32'd2 || fail_cnt !== 32'd1 || fifo_level !== 4'd1) begin failed++; $display("FAIL halt_freeze got=%0d/%0d/%0d exp=2/1/1", pass_cnt, fail_cnt, fifo_level); end
        tests++; if (first_fail_idx !== 32'd2 || unf_flag !== 1'b0) begin failed++; $display("FAIL halt_idx got=%0d unf=%b exp=2 unf=0", first_fail_idx, unf_flag); end
        do_clear();
        tests++; if (state_o !== 2'd0 || fifo_level !== '0 || pass_cnt !== 32'd0 || fail_cnt !== 32'd0) begin failed++; $display("FAIL halt_clear got=%0d/%0d/%0d/%0d exp=0/0/0/0", state_o, fifo_level, pass_cnt, fail_cnt); end
        tests++; if ({err_flag, ovf_flag, unf_flag} !== 3'b000 || first_fail_idx !== 32'd0 || first_fail_exp !== '0) begin failed++; $display("FAIL halt_clear_flags got=%b/%0d exp=000/0", {err_flag, ovf_flag, unf_flag}, first_fail_idx); end
`else
        tests++; if (state_o !== 2'd2) begin failed++; $display("FAIL nohalt_state got=%0d exp=2", state_o); end
        result(m_q[0]);
        tests++; if (pass_cnt !== 32'd3 || fail_cnt !== 32'd1 || fifo_level !== '0) begin failed++; $display("FAIL nohalt_continue got=%0d/%0d/%0d exp=3/1/0", pass_cnt, fail_cnt, fifo_level); end
        tests++; if (first_fail_idx !== 32'd2 || m_ffi !== 32'd2) begin failed++; $display("FAIL nohalt_idx got=%0d exp=2", first_fail_idx); end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bit0();
        test_extremes();
        test_overflow();
        test_underflow_gating();
        test_back_to_back();
        test_disable_hold();
        test_async_reset();
        test_stop_on_fail();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/da_result_checker.md
Name: da_result_checker

Overview:
- Consumer end of the random stimulus stream for the LUT-split DA datapath.
- Samples each address/weight set published by the stimulus generator and computes the golden DA partial sum for it.
- Queues the golden sums in arrival order and compares them, one per handshake, against the result stream of the DA unit under test.
- Reports pass/fail counts, sticky error flags and the first mismatch for testbench and on-chip self-test use.

Parameters:
- K, 8, number of weights; multiple of 4, at least 4.
- DATA_WIDTH_B, 8, signed weight width, 1..16.
- DEPTH, 8, expected-value FIFO depth; power of 2, at least 2.
- SUM_W, DATA_WIDTH_B+$clog2(K), signed golden/DUT result width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  checking enabled.
- clear  in  1  synchronous clear of all checker state.
- gen_done  in  1  generator has produced its first weight set.
- update_pulse_addr  in  1  new addr_array is valid this cycle.
- update_pulse_b  in  1  new B_temp is valid this cycle; informational only.
- addr_array  in  K-1  address bits; full address is {addr_array, 1'b1}.
- B_temp  in  K x DATA_WIDTH_B signed  current weights.
- dut_valid  in  1  DUT result valid this cycle.
- dut_result  in  SUM_W signed  DUT result.
- state_o  out  2  current state: 0 IDLE, 1 WAIT_GEN, 2 RUN, 3 HALT.
- fifo_level  out  $clog2(DEPTH)+1  number of queued expected values.
- pass_cnt  out  32  matching compares.
- fail_cnt  out  32  mismatching compares.
- err_flag  out  1  sticky; set on any mismatch.
- ovf_flag  out  1  sticky; set when an expected value is dropped.
- unf_flag  out  1  sticky; set when dut_valid arrives with the FIFO empty.
- first_fail_exp  out  SUM_W  expected value at the first mismatch.
- first_fail_got  out  SUM_W  DUT value at the first mismatch.
- first_fail_idx  out  32  compare index of the first mismatch (0-based, counts all compares).

Behaviour:
- Reset and clear: all outputs 0, FIFO empty, state IDLE. clear has the same effect on the next edge and has priority over all other activity in that cycle.

Golden sum:
- Full address bit 0 is always 1; full address bit j is addr_array[j-1] for j = 1..K-1.
- exp = sum over j of B_temp[j] for every j whose full address bit is 1.
- Computed sign-extended to SUM_W; no overflow is possible by construction.

Sampling:
- A sample is taken in any cycle with state RUN and update_pulse_addr=1, using addr_array and B_temp of that same cycle. B_temp is always used live, with no shadow copy.
- exp is registered and pushed into the FIFO one cycle later.
- An entry becomes poppable the cycle after its push. There is no bypass.

Compare:
- In any cycle with state RUN and dut_valid=1:
  - FIFO non-empty: pop the head and compare it with dut_result. Equal increments pass_cnt; unequal increments fail_cnt and sets err_flag. On the first mismatch only, capture first_fail_exp, first_fail_got and first_fail_idx.
  - FIFO empty: set unf_flag. No counter changes and no compare index is consumed.
- The compare index increments on every pop.
- Counters saturate at 0xFFFFFFFF.

FIFO boundaries:
- Push and pop in the same cycle while full: both take effect and the level is unchanged.
- Push while full with no pop: the push is dropped and ovf_flag is set.
- fifo_level is exact and bounded to 0..DEPTH.

State machine:
- IDLE -> WAIT_GEN when enable=1.
- WAIT_GEN -> RUN when gen_done=1. The first sample can occur in that same transition cycle only if the state is already RUN, i.e. sampling starts the cycle after entry to RUN.
- RUN -> IDLE when enable=0. The FIFO contents are retained, and flags and counters hold.
- Any state -> IDLE on clear.
- HALT exists only with the optional feature enabled; otherwise it is unreachable.

Ignored inputs:
- dut_valid and update pulses are ignored outside RUN.

Asynchronous reset mid-run:
- All state is discarded immediately.
- After release the checker restarts from IDLE and must again see enable and gen_done.

Optional Feature:
- Macro: DA_CHK_STOP_ON_FAIL_EN.
- Defined: the first mismatch moves the state RUN -> HALT on the next edge. In HALT, sampling, popping and all counters freeze, and the captured values hold. Only clear or rst leaves HALT.
- Undefined: checking continues after mismatches and HALT is never entered.

Test Plan:
- Basic match (K=8, W=8): B_temp all 1, addr_array=7'h7F, one pulse, then dut_valid with dut_result=8 two cycles later -> pass_cnt=1, fail_cnt=0, fifo_level back to 0.
- Bit-0 forcing: B_temp[j]=j+1, addr_array=0 -> expected 1. Drive dut_result=1 -> pass; repeat with dut_result=2 -> fail_cnt=1, err_flag=1, first_fail_exp=1, first_fail_got=2, first_fail_idx=1.
- Extremes: B_temp all -128, addr=7'h7F -> exp=-1024 passes. B_temp all 127 -> exp=1016 passes. SUM_W=11 and there is no wrap.
- Overflow: DEPTH=8, 9 pulses with no dut_valid -> fifo_level=8, ovf_flag=1. Then 8 matching results -> pass_cnt=8, level 0.
- Underflow and gating: dut_valid in RUN with an empty FIFO -> unf_flag=1 and counters unchanged. With gen_done=0, pulses produce no push and state stays WAIT_GEN.
- DA_CHK_STOP_ON_FAIL_EN: mismatch on compare 3 -> state HALT; later pulses and dut_valid leave the counters and fifo_level frozen. clear -> all outputs 0 and state IDLE.
